point_update_scheduler: RTL and testbench
=========================================

Name: point_update_scheduler

Overview:
Sequences one shared update_point datapath across all NUM_POINTS mass points of the soft-body car, once per physics frame. It holds the point state register file (pos/vel per point), feeds each point in index order with a begin_out/result_in handshake, and writes back the new state. It also latches per-frame acceleration, reports frame completion, and recovers from a stalled datapath via a timeout.

Parameters:
NUM_POINTS, 8, number of points in the register file (≥2)
POSITION_SIZE, 8, signed position width
VELOCITY_SIZE, 8, signed velocity width
ACCELERATION_SIZE, 8, signed acceleration width
TIMEOUT, 255, max cycles waited for result_in per point (≥2)

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous, active-low reset
frame_start_in  in  1  one-cycle pulse: start a sweep over all points
acc_x_in, acc_y_in  in  ACCELERATION_SIZE  frame acceleration, sampled at accepted frame_start_in
init_we_in  in  1  write one point's initial state
init_idx_in  in  $clog2(NUM_POINTS)  write index
init_pos_x_in, init_pos_y_in  in  POSITION_SIZE  initial position
init_vel_x_in, init_vel_y_in  in  VELOCITY_SIZE  initial velocity
rd_idx_in  in  $clog2(NUM_POINTS)  readout index
rd_pos_x_out, rd_pos_y_out  out  POSITION_SIZE  combinational readout of rd_idx_in
rd_vel_x_out, rd_vel_y_out  out  VELOCITY_SIZE  combinational readout
begin_out  out  1  one-cycle start to update_point
pos_x_out, pos_y_out  out  POSITION_SIZE  current point to datapath
vel_x_out, vel_y_out  out  VELOCITY_SIZE  current point to datapath
acc_x_out, acc_y_out  out  ACCELERATION_SIZE  latched frame acceleration
new_pos_x_in, new_pos_y_in  in  POSITION_SIZE  datapath result
new_vel_x_in, new_vel_y_in  in  VELOCITY_SIZE  datapath result
result_in  in  1  datapath result valid
busy_out  out  1  high while a sweep is in progress
point_idx_out  out  $clog2(NUM_POINTS)  index currently being processed
frame_done_out  out  1  one-cycle pulse when sweep completes
timeout_err_out  out  1  sticky: some point timed out
overrun_out  out  1  sticky: frame_start_in arrived while busy

Behaviour:
- Reset (rst_in low, async): state IDLE; all outputs 0; register file all 0; sticky flags cleared. Reset mid-sweep aborts immediately; no write-back.
- States: IDLE, ISSUE, WAIT, WRITE, DONE.
- IDLE: init_we_in writes entry init_idx_in next edge. frame_start_in: latch acc_*_in, idx←0, →ISSUE. If both in same cycle, init write happens first (visible to point 0).
- ISSUE (1 cycle): pos/vel_*_out loaded from entry idx, begin_out=1 this cycle; →WAIT, wait counter←0. Datapath outputs held stable through WAIT.
- WAIT: result_in ignored on the first WAIT cycle (guards against level-held result from prior point). From second cycle, result_in=1 → capture new_*_in, →WRITE. Counter increments each cycle; counter reaching TIMEOUT without result → timeout_err_out←1, keep old entry, →WRITE with no update.
- WRITE (1 cycle): store captured values at idx (if not timed out). If idx==NUM_POINTS-1 →DONE else idx+1, →ISSUE.
- DONE (1 cycle): frame_done_out=1, busy_out=0 next; →IDLE.
- busy_out=1 in ISSUE/WAIT/WRITE; 0 in IDLE/DONE. frame_start_in while busy_out=1 or in DONE: ignored, overrun_out←1. init_we_in while not IDLE: dropped.
- Min per-point latency 4 cycles (ISSUE, 2×WAIT, WRITE); min frame = 4·NUM_POINTS+1 cycles from accepted start to frame_done_out.
- No arithmetic on values; widths passed through unchanged. Sticky flags clear only on reset.

Test Plan:
- Init points 0..7 with pos=(i,−i), vel=(1,2); model returns pos+vel 3 cycles after begin -> after frame_done_out, rd of point 3 gives pos=(4,−1), vel=(1,2); exactly 8 begin_out pulses.
- acc_x_in=0, acc_y_in=−1 at frame_start_in, change to 5 mid-sweep -> acc_y_out stays −1 entire frame.
- result_in held high constantly -> each point still gets its own begin_out; frame completes in 4·8+1=33 cycles.
- Model never answers point 2, TIMEOUT=10 -> timeout_err_out=1, point 2 unchanged, points 3..7 updated, frame_done_out pulses.
- frame_start_in during WAIT -> overrun_out=1, sweep unaffected, no second sweep starts.
- rst_in low during WAIT on point 5 -> all outputs 0 immediately, all entries read 0, busy_out=0.

Source files
------------

// File: rtl/point_update_scheduler.sv
// Point update scheduler: sweeps the shared update_point datapath
// over every mass point once per physics frame and writes back state.
module point_update_scheduler #(
    parameter int NUM_POINTS        = 8,
    parameter int POSITION_SIZE     = 8,
    parameter int VELOCITY_SIZE     = 8,
    parameter int ACCELERATION_SIZE = 8,
    parameter int TIMEOUT           = 255
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  frame_start_in,
    input  logic [ACCELERATION_SIZE-1:0]          acc_x_in,
    input  logic [ACCELERATION_SIZE-1:0]          acc_y_in,
    input  logic                                  init_we_in,
    input  logic [$clog2(NUM_POINTS)-1:0]         init_idx_in,
    input  logic [POSITION_SIZE-1:0]              init_pos_x_in,
    input  logic [POSITION_SIZE-1:0]              init_pos_y_in,
    input  logic [VELOCITY_SIZE-1:0]              init_vel_x_in,
    input  logic [VELOCITY_SIZE-1:0]              init_vel_y_in,
    input  logic [$clog2(NUM_POINTS)-1:0]         rd_idx_in,
    output logic [POSITION_SIZE-1:0]              rd_pos_x_out,
    output logic [POSITION_SIZE-1:0]              rd_pos_y_out,
    output logic [VELOCITY_SIZE-1:0]              rd_vel_x_out,
    output logic [VELOCITY_SIZE-1:0]              rd_vel_y_out,
    output logic                                  begin_out,
    output logic [POSITION_SIZE-1:0]              pos_x_out,
    output logic [POSITION_SIZE-1:0]              pos_y_out,
    output logic [VELOCITY_SIZE-1:0]              vel_x_out,
    output logic [VELOCITY_SIZE-1:0]              vel_y_out,
    output logic [ACCELERATION_SIZE-1:0]          acc_x_out,
    output logic [ACCELERATION_SIZE-1:0]          acc_y_out,
    input  logic [POSITION_SIZE-1:0]              new_pos_x_in,
    input  logic [POSITION_SIZE-1:0]              new_pos_y_in,
    input  logic [VELOCITY_SIZE-1:0]              new_vel_x_in,
    input  logic [VELOCITY_SIZE-1:0]              new_vel_y_in,
    input  logic                                  result_in,
    output logic                                  busy_out,
    output logic [$clog2(NUM_POINTS)-1:0]         point_idx_out,
    output logic                                  frame_done_out,
    output logic                                  timeout_err_out,
    output logic                                  overrun_out
);

    localparam int IW = $clog2(NUM_POINTS);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST = IW'(NUM_POINTS - 1);
    localparam logic [CW-1:0] CNT_END = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic begin_q, begin_d, done_q, done_d, busy_q, busy_d;
    logic tmo_q, tmo_d, terr_q, terr_d, ovr_q, ovr_d;
    logic [POSITION_SIZE-1:0] px_q [NUM_POINTS], px_d [NUM_POINTS];
    logic [POSITION_SIZE-1:0] py_q [NUM_POINTS], py_d [NUM_POINTS];
    logic [VELOCITY_SIZE-1:0] vx_q [NUM_POINTS], vx_d [NUM_POINTS];
    logic [VELOCITY_SIZE-1:0] vy_q [NUM_POINTS], vy_d [NUM_POINTS];
    logic [POSITION_SIZE-1:0] opx_q, opx_d, opy_q, opy_d;
    logic [VELOCITY_SIZE-1:0] ovx_q, ovx_d, ovy_q, ovy_d;
    logic [POSITION_SIZE-1:0] cpx_q, cpx_d, cpy_q, cpy_d;
    logic [VELOCITY_SIZE-1:0] cvx_q, cvx_d, cvy_q, cvy_d;
    logic [ACCELERATION_SIZE-1:0] ax_q, ax_d, ay_q, ay_d;
    logic ld;
    logic [IW-1:0] ld_idx;

    // Next-state: sweep sequencing, register file writes, datapath load
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        cnt_d = cnt_q;
        begin_d = 1'b0;
        done_d = 1'b0;
        busy_d = busy_q;
        tmo_d = tmo_q;
        terr_d = terr_q;
        ovr_d = ovr_q;
        px_d = px_q;
        py_d = py_q;
        vx_d = vx_q;
        vy_d = vy_q;
        opx_d = opx_q;
        opy_d = opy_q;
        ovx_d = ovx_q;
        ovy_d = ovy_q;
        cpx_d = cpx_q;
        cpy_d = cpy_q;
        cvx_d = cvx_q;
        cvy_d = cvy_q;
        ax_d = ax_q;
        ay_d = ay_q;
        ld = 1'b0;
        ld_idx = idx_q;
        if (frame_start_in && state_q != IDLE) begin
            ovr_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (init_we_in) begin
                    px_d[init_idx_in] = init_pos_x_in;
                    py_d[init_idx_in] = init_pos_y_in;
                    vx_d[init_idx_in] = init_vel_x_in;
                    vy_d[init_idx_in] = init_vel_y_in;
                end
                if (frame_start_in) begin
                    ax_d = acc_x_in;
                    ay_d = acc_y_in;
                    idx_d = '0;
                    state_d = ISSUE;
                    begin_d = 1'b1;
                    busy_d = 1'b1;
                    ld = 1'b1;
                    ld_idx = '0;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // first WAIT cycle ignores a result level left from the last point
                if (cnt_q != '0 && result_in) begin
                    cpx_d = new_pos_x_in;
                    cpy_d = new_pos_y_in;
                    cvx_d = new_vel_x_in;
                    cvy_d = new_vel_y_in;
                    tmo_d = 1'b0;
                    state_d = WRITE;
                end else if (cnt_q == CNT_END) begin
                    tmo_d = 1'b1;
                    terr_d = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!tmo_q) begin
                    px_d[idx_q] = cpx_q;
                    py_d[idx_q] = cpy_q;
                    vx_d[idx_q] = cvx_q;
                    vy_d[idx_q] = cvy_q;
                end
                if (idx_q == LAST) begin
                    state_d = DONE;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    idx_d = idx_q + 1'b1;
                    state_d = ISSUE;
                    begin_d = 1'b1;
                    ld = 1'b1;
                    ld_idx = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // read after writes so a same-cycle init write reaches point 0
        if (ld) begin
            opx_d = px_d[ld_idx];
            opy_d = py_d[ld_idx];
            ovx_d = vx_d[ld_idx];
            ovy_d = vy_d[ld_idx];
        end
    end

    // State and register file, cleared asynchronously
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            idx_q <= '0;
            cnt_q <= '0;
            begin_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            tmo_q <= 1'b0;
            terr_q <= 1'b0;
            ovr_q <= 1'b0;
            for (int i = 0; i < NUM_POINTS; i++) begin
                px_q[i] <= '0;
                py_q[i] <= '0;
                vx_q[i] <= '0;
                vy_q[i] <= '0;
            end
            opx_q <= '0;
            opy_q <= '0;
            ovx_q <= '0;
            ovy_q <= '0;
            cpx_q <= '0;
            cpy_q <= '0;
            cvx_q <= '0;
            cvy_q <= '0;
            ax_q <= '0;
            ay_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            begin_q <= begin_d;
            done_q <= done_d;
            busy_q <= busy_d;
            tmo_q <= tmo_d;
            terr_q <= terr_d;
            ovr_q <= ovr_d;
            px_q <= px_d;
            py_q <= py_d;
            vx_q <= vx_d;
            vy_q <= vy_d;
            opx_q <= opx_d;
            opy_q <= opy_d;
            ovx_q <= ovx_d;
            ovy_q <= ovy_d;
            cpx_q <= cpx_d;
            cpy_q <= cpy_d;
            cvx_q <= cvx_d;
            cvy_q <= cvy_d;
            ax_q <= ax_d;
            ay_q <= ay_d;
        end
    end

    assign rd_pos_x_out = px_q[rd_idx_in];
    assign rd_pos_y_out = py_q[rd_idx_in];
    assign rd_vel_x_out = vx_q[rd_idx_in];
    assign rd_vel_y_out = vy_q[rd_idx_in];
    assign begin_out = begin_q;
    assign pos_x_out = opx_q;
    assign pos_y_out = opy_q;
    assign vel_x_out = ovx_q;
    assign vel_y_out = ovy_q;
    assign acc_x_out = ax_q;
    assign acc_y_out = ay_q;
    assign busy_out = busy_q;
    assign point_idx_out = idx_q;
    assign frame_done_out = done_q;
    assign timeout_err_out = terr_q;
    assign overrun_out = ovr_q;

endmodule

// File: tb/tb_point_update_scheduler.sv
// Bench for point_update_scheduler: a datapath model answers begin_out
// pulses, and a queue holds the point each begin_out should present.
module tb_point_update_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0;
    logic [7:0] acc_x_in = '0, acc_y_in = '0;
    logic init_we = 1'b0;
    logic [2:0] init_idx = '0;
    logic [7:0] ipx = '0, ipy = '0, ivx = '0, ivy = '0;
    logic [2:0] rd_idx = '0;
    logic [7:0] rpx, rpy, rvx, rvy;
    logic begin_out;
    logic [7:0] pos_x_out, pos_y_out, vel_x_out, vel_y_out;
    logic [7:0] acc_x_out, acc_y_out;
    logic [7:0] npx = '0, npy = '0, nvx = '0, nvy = '0;
    logic result = 1'b0;
    logic busy, frame_done, terr, ovr;
    logic [2:0] pidx;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] px, py, vx, vy;
    } beg_t;
    beg_t sb[$];

    logic [7:0] mpx [8], mpy [8], mvx [8], mvy [8];
    int n_cmp = 0;
    int n_bad = 0;
    int mode = 0;
    int skip = -1;
    int cd = 0;
    int cyc;
    bit chk_acc = 0;
    logic [7:0] exp_ay = '0;
    int ovr_at = -1;

    always #5 clk = ~clk;

    point_update_scheduler #(
        .NUM_POINTS(8), .POSITION_SIZE(8), .VELOCITY_SIZE(8),
        .ACCELERATION_SIZE(8), .TIMEOUT(10)
    ) dut (
        .clk_in(clk), .rst_in(rst_n), .frame_start_in(frame_start),
        .acc_x_in(acc_x_in), .acc_y_in(acc_y_in),
        .init_we_in(init_we), .init_idx_in(init_idx),
        .init_pos_x_in(ipx), .init_pos_y_in(ipy),
        .init_vel_x_in(ivx), .init_vel_y_in(ivy),
        .rd_idx_in(rd_idx),
        .rd_pos_x_out(rpx), .rd_pos_y_out(rpy),
        .rd_vel_x_out(rvx), .rd_vel_y_out(rvy),
        .begin_out(begin_out),
        .pos_x_out(pos_x_out), .pos_y_out(pos_y_out),
        .vel_x_out(vel_x_out), .vel_y_out(vel_y_out),
        .acc_x_out(acc_x_out), .acc_y_out(acc_y_out),
        .new_pos_x_in(npx), .new_pos_y_in(npy),
        .new_vel_x_in(nvx), .new_vel_y_in(nvy),
        .result_in(result), .busy_out(busy), .point_idx_out(pidx),
        .frame_done_out(frame_done), .timeout_err_out(terr),
        .overrun_out(ovr)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // datapath model: answers pos+vel, vel unchanged, per mode
    always @(negedge clk) begin
        beg_t e;
        npx = pos_x_out + vel_x_out;
        npy = pos_y_out + vel_y_out;
        nvx = vel_x_out;
        nvy = vel_y_out;
        if (begin_out) begin
            if (sb.size() == 0) begin
                check("extra_begin", 32'(pidx), 32'hffff);
            end else begin
                e = sb.pop_front();
                check("beg_idx", 32'(pidx), 32'(e.idx));
                check("beg_pos", {pos_x_out, pos_y_out}, {e.px, e.py});
                check("beg_vel", {vel_x_out, vel_y_out}, {e.vx, e.vy});
            end
            cd = (mode == 2 && int'(pidx) == skip) ? 0 : 3;
        end else if (cd != 0) begin
            cd = cd - 1;
        end
        result = (mode == 1) || (cd == 1);
    end

    task automatic kick(input logic [7:0] ax, input logic [7:0] ay);
        for (int i = 0; i < 8; i++)
            sb.push_back({3'(i), mpx[i], mpy[i], mvx[i], mvy[i]});
        acc_x_in = ax;
        acc_y_in = ay;
        frame_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_start = 1'b0;
        cyc = 1;
    endtask

    task automatic run_to_done();
        while (!frame_done) begin
            if (chk_acc) check("acc_y_hold", 32'(acc_y_out), 32'(exp_ay));
            if (cyc == 5) acc_y_in = 8'd5;
            if (cyc == ovr_at) frame_start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            frame_start = 1'b0;
            cyc++;
            if (cyc > 500) begin
                check("frame_bound", 32'(cyc), 32'd0);
                break;
            end
        end
    endtask

    task automatic update_model();
        for (int i = 0; i < 8; i++)
            if (!(mode == 2 && i == skip)) begin
                mpx[i] = mpx[i] + mvx[i];
                mpy[i] = mpy[i] + mvy[i];
            end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_idx = 3'(i);
            #1;
            check({tag, "_pos"}, {rpx, rpy}, {mpx[i], mpy[i]});
            check({tag, "_vel"}, {rvx, rvy}, {mvx[i], mvy[i]});
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_begin", 32'(begin_out), 32'd0);
        check("rst_flags", {frame_done, terr, ovr}, 32'd0);
        check("rst_idx", 32'(pidx), 32'd0);
        check("rst_dp", {pos_x_out, pos_y_out, acc_x_out, acc_y_out}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mpx[i] = 8'(i);
            mpy[i] = 8'(-i);
            mvx[i] = 8'd1;
            mvy[i] = 8'd2;
            init_we = 1'b1;
            init_idx = 3'(i);
            ipx = mpx[i];
            ipy = mpy[i];
            ivx = mvx[i];
            ivy = mvy[i];
            @(negedge clk);
        end
        init_we = 1'b0;
        check_all("init");

        // frame 1: acc latched, input changed mid-sweep
        chk_acc = 1;
        exp_ay = 8'hff;
        kick(8'd0, 8'hff);
        run_to_done();
        chk_acc = 0;
        check("acc_x", 32'(acc_x_out), 32'd0);
        check("f1_left", 32'(sb.size()), 32'd0);
        update_model();
        rd_idx = 3'd3;
        #1;
        check("f1_p3", {rpx, rpy, rvx, rvy}, {8'd4, 8'hff, 8'd1, 8'd2});
        check_all("f1");
        check("f1_flags", {terr, ovr}, 32'd0);

        // frame 2: result held high, minimum frame length
        mode = 1;
        @(negedge clk);
        kick(8'd1, 8'd2);
        run_to_done();
        check("f2_cycles", 32'(cyc), 32'd33);
        check("f2_left", 32'(sb.size()), 32'd0);
        update_model();
        check_all("f2");
        mode = 0;
        @(negedge clk);

        // frame 3: point 2 never answered
        mode = 2;
        skip = 2;
        kick(8'd0, 8'd0);
        run_to_done();
        check("f3_terr", 32'(terr), 32'd1);
        check("f3_left", 32'(sb.size()), 32'd0);
        update_model();
        check_all("f3");
        mode = 0;
        skip = -1;

        // frame 4: frame_start during WAIT
        @(negedge clk);
        ovr_at = 3;
        kick(8'd0, 8'd0);
        run_to_done();
        ovr_at = -1;
        check("f4_ovr", 32'(ovr), 32'd1);
        update_model();
        check_all("f4");
        repeat (5) @(negedge clk);
        check("f4_no_second", 32'(busy), 32'd0);
        check("f4_left", 32'(sb.size()), 32'd0);

        // frame 5: reset while waiting on point 5
        kick(8'd3, 8'd4);
        while (!(begin_out && pidx == 3'd5) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("f5_reach", 32'(pidx), 32'd5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_flags", {begin_out, frame_done, terr, ovr}, 32'd0);
        check("mid_dp", {pos_x_out, pos_y_out, acc_x_out, acc_y_out}, 32'd0);
        check("mid_idx", 32'(pidx), 32'd0);
        sb.delete();
        for (int i = 0; i < 8; i++) begin
            mpx[i] = '0;
            mpy[i] = '0;
            mvx[i] = '0;
            mvy[i] = '0;
        end
        check_all("mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_busy", 32'(busy), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
